// File: rtl/arch_pkg.sv
// arch_pkg: shared types for the memory bus arbiter (sizes, FSM states, latched bus request).
package arch_pkg;
   localparam int BUS_AW = 64;
   localparam int BUS_DW = 64;
   typedef enum logic [2:0] {SZ_B, SZ_H, SZ_W, SZ_D} msize_t;
   typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} arb_state_t;
   typedef struct packed {
      logic              write;
      logic [BUS_AW-1:0] addr;
      msize_t            size;
      logic [7:0]        strobe;
      logic [BUS_DW-1:0] wdata;
   } bus_req_t;
endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between instruction fetch and the data port,
// one transaction at a time, with fetch-kill support for redirects.
module mem_bus_arbiter
   import arch_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter bit RR_EN  = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ireq_valid,
   input  logic [ADDR_W-1:0] ireq_addr,
   input  logic              ikill,
   output logic              iresp_ok,
   output logic [31:0]       iresp_data,
   input  logic              dreq_valid,
   input  logic              dreq_write,
   input  logic [ADDR_W-1:0] dreq_addr,
   input  logic [2:0]        dreq_size,
   input  logic [7:0]        dreq_strobe,
   input  logic [DATA_W-1:0] dreq_wdata,
   output logic              dresp_ok,
   output logic [DATA_W-1:0] dresp_data,
   output logic              bus_valid,
   output logic              bus_write,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [2:0]        bus_size,
   output logic [7:0]        bus_strobe,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ok,
   input  logic [DATA_W-1:0] bus_data
);
   arb_state_t        state, state_nx;
   bus_req_t          req, req_nx;
   logic              last_d, drop, ia2, fv, grant, grant_d;
   logic [31:0]       idata;
   logic [DATA_W-1:0] ddata;

   // Data wins unless fetch is alone, or round-robin says it is fetch's turn.
   function automatic logic pick_d(input logic f, input logic d, input logic ld);
      return d & (~f | (RR_EN ? ~ld : 1'b1));
   endfunction

   assign fv      = ireq_valid & ~ikill;
   assign grant_d = pick_d(fv, dreq_valid, last_d);

   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      case (state)
         IDLE: begin
            grant    = fv | dreq_valid;
            state_nx = grant ? (grant_d ? BUSY_D : BUSY_I) : IDLE;
         end
         BUSY_I:  state_nx = bus_ok ? RESP_I : BUSY_I;
         BUSY_D:  state_nx = bus_ok ? RESP_D : BUSY_D;
         default: state_nx = IDLE;
      endcase
      req_nx.write  = grant_d & dreq_write;
      req_nx.addr   = grant_d ? BUS_AW'(dreq_addr) : BUS_AW'(ireq_addr);
      req_nx.size   = grant_d ? msize_t'(dreq_size) : SZ_W;
      req_nx.strobe = (grant_d & dreq_write) ? dreq_strobe : 8'h00;
      req_nx.wdata  = grant_d ? BUS_DW'(dreq_wdata) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req       <= '0;
         bus_valid <= 1'b0;
         last_d    <= 1'b0;
         drop      <= 1'b0;
         ia2       <= 1'b0;
         idata     <= '0;
         ddata     <= '0;
      end else begin
         if (grant) begin
            req       <= req_nx;
            bus_valid <= 1'b1;
            last_d    <= grant_d;
            ia2       <= ireq_addr[2];
         end
         if ((state == BUSY_I || state == BUSY_D) && bus_ok) bus_valid <= 1'b0;
         if (state == BUSY_I && bus_ok) idata <= ia2 ? bus_data[63:32] : bus_data[31:0];
         if (state == BUSY_D && bus_ok) ddata <= bus_data;
         // A kill in BUSY_I lets the bus finish but poisons the response.
         if (state == IDLE) drop <= 1'b0;
         else if (state == BUSY_I && ikill) drop <= 1'b1;
      end
   end

   assign iresp_ok   = (state == RESP_I) & ~drop & ~ikill;
   assign dresp_ok   = (state == RESP_D);
   assign iresp_data = idata;
   assign dresp_data = ddata;
   assign bus_write  = req.write;
   assign bus_addr   = req.addr[ADDR_W-1:0];
   assign bus_size   = req.size;
   assign bus_strobe = req.strobe;
   assign bus_wdata  = req.wdata[DATA_W-1:0];
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of fetch, ties, store stall, fetch kill and async reset.
module tb_mem_bus_arbiter;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        ireq_valid = 0, ikill = 0, dreq_valid = 0, dreq_write = 0, bus_ok = 0;
   logic [63:0] ireq_addr = 0, dreq_addr = 0, dreq_wdata = 0, bus_data = 0;
   logic [2:0]  dreq_size = 0;
   logic [7:0]  dreq_strobe = 0;
   logic        iresp_ok, dresp_ok, bus_valid, bus_write;
   logic [31:0] iresp_data;
   logic [63:0] dresp_data, bus_addr, bus_wdata;
   logic [2:0]  bus_size;
   logic [7:0]  bus_strobe;
   logic        r_iresp_ok, r_dresp_ok, r_bus_valid, r_bus_write;
   logic [31:0] r_iresp_data;
   logic [63:0] r_dresp_data, r_bus_addr, r_bus_wdata;
   logic [2:0]  r_bus_size;
   logic [7:0]  r_bus_strobe;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .RR_EN(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ikill(ikill),
      .iresp_ok(iresp_ok), .iresp_data(iresp_data), .dreq_valid(dreq_valid), .dreq_write(dreq_write),
      .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
      .dresp_ok(dresp_ok), .dresp_data(dresp_data), .bus_valid(bus_valid), .bus_write(bus_write),
      .bus_addr(bus_addr), .bus_size(bus_size), .bus_strobe(bus_strobe), .bus_wdata(bus_wdata),
      .bus_ok(bus_ok), .bus_data(bus_data));

   mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .RR_EN(1'b1)) u_rr (
      .clk(clk), .rst_n(rst_n), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ikill(ikill),
      .iresp_ok(r_iresp_ok), .iresp_data(r_iresp_data), .dreq_valid(dreq_valid), .dreq_write(dreq_write),
      .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
      .dresp_ok(r_dresp_ok), .dresp_data(r_dresp_data), .bus_valid(r_bus_valid), .bus_write(r_bus_write),
      .bus_addr(r_bus_addr), .bus_size(r_bus_size), .bus_strobe(r_bus_strobe), .bus_wdata(r_bus_wdata),
      .bus_ok(bus_ok), .bus_data(bus_data));

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic ok_cycle(input logic [63:0] d);
      bus_ok = 1'b1;
      bus_data = d;
      step();
      bus_ok = 1'b0;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      {ireq_valid, ikill, dreq_valid, dreq_write, bus_ok} = '0;
      {ireq_addr, dreq_addr, dreq_wdata, bus_data} = '0;
      dreq_size = 3'd0;
      dreq_strobe = 8'h00;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      checks++; if ({iresp_ok, dresp_ok, bus_valid, bus_write} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {iresp_ok, dresp_ok, bus_valid, bus_write}); end
      checks++; if ({bus_addr, bus_wdata, bus_size, bus_strobe, iresp_data, dresp_data} !== '0) begin errors++; $display("FAIL reset_buses got nonzero want 0"); end
      do_reset();
   endtask

   task automatic test_fetch;
      do_reset();
      ireq_valid = 1'b1; ireq_addr = 64'h1004;
      step();
      checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got %b want 1", bus_valid); end
      checks++; if (bus_addr !== 64'h1004) begin errors++; $display("FAIL fetch_addr got %h want 1004", bus_addr); end
      checks++; if ({bus_size, bus_strobe, bus_write} !== {3'd2, 8'h00, 1'b0}) begin errors++; $display("FAIL fetch_fields got %h/%h/%b want 2/00/0", bus_size, bus_strobe, bus_write); end
      step();
      checks++; if (iresp_ok !== 1'b0) begin errors++; $display("FAIL fetch_early got %b want 0", iresp_ok); end
      ok_cycle(64'hAAAA_BBBB_CCCC_DDDD);
      checks++; if (iresp_ok !== 1'b1) begin errors++; $display("FAIL fetch_ok got %b want 1", iresp_ok); end
      checks++; if (iresp_data !== 32'hAAAABBBB) begin errors++; $display("FAIL fetch_data got %h want aaaabbbb", iresp_data); end
      checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL fetch_drop_valid got %b want 0", bus_valid); end
      ireq_valid = 1'b0;
      step();
      checks++; if (iresp_ok !== 1'b0) begin errors++; $display("FAIL fetch_pulse got %b want 0", iresp_ok); end
      checks++; if (iresp_data !== 32'hAAAABBBB) begin errors++; $display("FAIL fetch_hold got %h want aaaabbbb", iresp_data); end
      step();
      checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL fetch_idle got %b want 0", bus_valid); end
   endtask

   task automatic test_tie_fixed;
      do_reset();
      ireq_valid = 1'b1; ireq_addr = 64'h1000;
      dreq_valid = 1'b1; dreq_write = 1'b0; dreq_addr = 64'h3000; dreq_size = 3'd3; dreq_strobe = 8'hFF;
      step();
      checks++; if (bus_addr !== 64'h3000) begin errors++; $display("FAIL tie1_addr got %h want 3000", bus_addr); end
      checks++; if ({bus_write, bus_size, bus_strobe} !== {1'b0, 3'd3, 8'h00}) begin errors++; $display("FAIL tie1_load got %b/%h/%h want 0/3/00", bus_write, bus_size, bus_strobe); end
      ok_cycle(64'h0123_4567_89AB_CDEF);
      checks++; if ({dresp_ok, iresp_ok} !== 2'b10) begin errors++; $display("FAIL tie1_resp got %b want 10", {dresp_ok, iresp_ok}); end
      checks++; if (dresp_data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL tie1_data got %h want 0123456789abcdef", dresp_data); end
      dreq_addr = 64'h3008;
      step();
      checks++; if ({dresp_ok, bus_valid} !== 2'b00) begin errors++; $display("FAIL tie_resp_nogrant got %b want 00", {dresp_ok, bus_valid}); end
      step();
      checks++; if (bus_addr !== 64'h3008) begin errors++; $display("FAIL tie2_addr got %h want 3008", bus_addr); end
      ok_cycle(64'h5);
      dreq_valid = 1'b0;
      step();
      step();
      checks++; if (bus_addr !== 64'h1000 || bus_size !== 3'd2) begin errors++; $display("FAIL tie3_fetch got %h/%h want 1000/2", bus_addr, bus_size); end
      ok_cycle(64'hAAAA_BBBB_CCCC_DDDD);
      checks++; if (iresp_ok !== 1'b1 || iresp_data !== 32'hCCCCDDDD) begin errors++; $display("FAIL tie3_resp got %b/%h want 1/ccccdddd", iresp_ok, iresp_data); end
      ireq_valid = 1'b0;
      step();
   endtask

   task automatic test_tie_rr;
      do_reset();
      ireq_valid = 1'b1; ireq_addr = 64'h1000;
      dreq_valid = 1'b1; dreq_write = 1'b0; dreq_addr = 64'h3000; dreq_size = 3'd2;
      step();
      checks++; if (r_bus_addr !== 64'h3000) begin errors++; $display("FAIL rr1_addr got %h want 3000", r_bus_addr); end
      ok_cycle(64'h1);
      checks++; if (r_dresp_ok !== 1'b1) begin errors++; $display("FAIL rr1_ok got %b want 1", r_dresp_ok); end
      dreq_addr = 64'h3010;
      step();
      step();
      checks++; if (r_bus_addr !== 64'h1000) begin errors++; $display("FAIL rr2_addr got %h want 1000", r_bus_addr); end
      ok_cycle(64'h2);
      checks++; if (r_iresp_ok !== 1'b1) begin errors++; $display("FAIL rr2_ok got %b want 1", r_iresp_ok); end
      ireq_addr = 64'h1008;
      step();
      step();
      checks++; if (r_bus_addr !== 64'h3010) begin errors++; $display("FAIL rr3_addr got %h want 3010", r_bus_addr); end
      ok_cycle(64'h3);
      dreq_valid = 1'b0;
      step();
      step();
      checks++; if (r_bus_addr !== 64'h1008) begin errors++; $display("FAIL rr4_addr got %h want 1008", r_bus_addr); end
      ok_cycle(64'h4);
      ireq_valid = 1'b0;
      step();
   endtask

   task automatic test_store_stall;
      do_reset();
      dreq_valid = 1'b1; dreq_write = 1'b1; dreq_addr = 64'h2000; dreq_size = 3'd3;
      dreq_strobe = 8'hFF; dreq_wdata = 64'h1122_3344_5566_7788;
      step();
      checks++; if ({bus_valid, bus_write, bus_size, bus_strobe} !== {1'b1, 1'b1, 3'd3, 8'hFF}) begin errors++; $display("FAIL st_fields got %b/%b/%h/%h want 1/1/3/ff", bus_valid, bus_write, bus_size, bus_strobe); end
      checks++; if (bus_addr !== 64'h2000 || bus_wdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL st_addr_data got %h/%h want 2000/1122334455667788", bus_addr, bus_wdata); end
      dreq_valid = 1'b0; dreq_wdata = 64'h0; dreq_addr = 64'h0; dreq_strobe = 8'h00;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (bus_valid !== 1'b1 || dresp_ok !== 1'b0 || bus_addr !== 64'h2000 || bus_wdata !== 64'h1122_3344_5566_7788 || bus_strobe !== 8'hFF) begin errors++; $display("FAIL st_stall%0d got %b/%b/%h/%h want 1/0/2000/1122334455667788", i, bus_valid, dresp_ok, bus_addr, bus_wdata); end
      end
      ok_cycle(64'h0);
      checks++; if ({dresp_ok, bus_valid} !== 2'b10) begin errors++; $display("FAIL st_done got %b want 10", {dresp_ok, bus_valid}); end
      step();
      checks++; if ({dresp_ok, bus_valid} !== 2'b00) begin errors++; $display("FAIL st_pulse got %b want 00", {dresp_ok, bus_valid}); end
   endtask

   task automatic test_kill;
      do_reset();
      ireq_valid = 1'b1; ireq_addr = 64'h1000;
      step();
      ikill = 1'b1; ireq_valid = 1'b0;
      dreq_valid = 1'b1; dreq_write = 1'b0; dreq_addr = 64'h3000; dreq_size = 3'd3;
      step();
      ikill = 1'b0;
      step();
      ok_cycle(64'hFFFF_FFFF_FFFF_FFFF);
      checks++; if (iresp_ok !== 1'b0) begin errors++; $display("FAIL kill_busy got %b want 0", iresp_ok); end
      step();
      checks++; if (iresp_ok !== 1'b0 || bus_valid !== 1'b0) begin errors++; $display("FAIL kill_idle got %b/%b want 0/0", iresp_ok, bus_valid); end
      step();
      checks++; if (bus_valid !== 1'b1 || bus_addr !== 64'h3000) begin errors++; $display("FAIL kill_dgrant got %b/%h want 1/3000", bus_valid, bus_addr); end
      ok_cycle(64'h77);
      checks++; if (dresp_ok !== 1'b1 || dresp_data !== 64'h77) begin errors++; $display("FAIL kill_dresp got %b/%h want 1/77", dresp_ok, dresp_data); end
      dreq_valid = 1'b0;
      step();
      ireq_valid = 1'b1; ireq_addr = 64'h1004;
      step();
      step();
      ikill = 1'b1; ireq_valid = 1'b0;
      ok_cycle(64'h1);
      ikill = 1'b0;
      #1;
      checks++; if (iresp_ok !== 1'b0) begin errors++; $display("FAIL kill_sameok got %b want 0", iresp_ok); end
      step();
      ireq_valid = 1'b1; ireq_addr = 64'h1000;
      step();
      step();
      ok_cycle(64'h9);
      checks++; if (iresp_ok !== 1'b1) begin errors++; $display("FAIL kill_after got %b want 1", iresp_ok); end
      ikill = 1'b1;
      #1;
      checks++; if (iresp_ok !== 1'b0) begin errors++; $display("FAIL kill_resp got %b want 0", iresp_ok); end
      ikill = 1'b0; ireq_valid = 1'b0;
      step();
   endtask

   task automatic test_async_reset;
      do_reset();
      dreq_valid = 1'b1; dreq_write = 1'b1; dreq_addr = 64'h3000; dreq_size = 3'd3; dreq_strobe = 8'h0F; dreq_wdata = 64'hDEAD;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({bus_valid, bus_write, dresp_ok, iresp_ok} !== 4'b0 || bus_addr !== 64'h0 || bus_strobe !== 8'h00 || bus_wdata !== 64'h0) begin errors++; $display("FAIL arst_outputs got %b/%h/%h want 0/0/0", {bus_valid, bus_write, dresp_ok, iresp_ok}, bus_addr, bus_wdata); end
      dreq_valid = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if ({bus_valid, dresp_ok, iresp_ok} !== 3'b000) begin errors++; $display("FAIL arst_quiet%0d got %b want 000", i, {bus_valid, dresp_ok, iresp_ok}); end
      end
      ireq_valid = 1'b1; ireq_addr = 64'h1004;
      step();
      checks++; if (bus_valid !== 1'b1 || bus_addr !== 64'h1004) begin errors++; $display("FAIL arst_fetch got %b/%h want 1/1004", bus_valid, bus_addr); end
      ok_cycle(64'h1234_5678_0000_0000);
      checks++; if (iresp_ok !== 1'b1 || iresp_data !== 32'h12345678) begin errors++; $display("FAIL arst_resp got %b/%h want 1/12345678", iresp_ok, iresp_data); end
      ireq_valid = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_tie_fixed();
      test_tie_rr();
      test_store_stall();
      test_kill();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
